// File: rtl/mgmt_gpio_bank.sv
// mgmt_gpio_bank: NGPIO management GPIOs on Wishbone with set/clear, synced inputs and edge interrupts.
// Define MGMT_GPIO_BLINK_EN to add BLINK_MASK/BLINK_PERIOD (regs 8-9) hardware blinking.
module mgmt_gpio_bank #(
  parameter int NGPIO = 8,
  parameter int SYNC_STAGES = 2,
  parameter logic [NGPIO-1:0] OEB_RESET = {NGPIO{1'b1}}
) (
  input  logic             core_clk,
  input  logic             core_rst,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic             wb_we_i,
  input  logic [3:0]       wb_sel_i,
  input  logic [5:0]       wb_adr_i,
  input  logic [31:0]      wb_dat_i,
  output logic [31:0]      wb_dat_o,
  output logic             wb_ack_o,
  input  logic [NGPIO-1:0] gpio_in,
  output logic [NGPIO-1:0] gpio_out,
  output logic [NGPIO-1:0] gpio_oeb,
  output logic             irq
);
  logic [NGPIO-1:0] out_r, oeb_r, mask_r, edge_r, pend_r, prev, in_s;
  logic [NGPIO-1:0] bm, wd, ev, w1c, out_bus, out_nxt;
  logic [SYNC_STAGES-1:0][NGPIO-1:0] sync_q;
  logic [31:0] lanes, rd;
  logic [3:0] a;
  logic acc, wr;
  logic unused;
  assign a = wb_adr_i[5:2];
  assign acc = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr = acc & wb_we_i;
  assign lanes = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign bm = lanes[NGPIO-1:0];
  assign wd = wb_dat_i[NGPIO-1:0] & bm;
  assign in_s = sync_q[SYNC_STAGES-1];
  assign ev = (edge_r & in_s & ~prev) | (~edge_r & ~in_s & prev);
  assign w1c = (wr && a == 4'd5) ? wd : '0;
  assign out_bus = !wr ? out_r :
                   a == 4'd0 ? (out_r & ~bm) | wd :
                   a == 4'd6 ? out_r | wd :
                   a == 4'd7 ? out_r & ~wd : out_r;
  assign gpio_out = out_r;
  assign gpio_oeb = oeb_r;
  assign unused = ^{wb_adr_i[1:0], wb_dat_i, lanes};
`ifdef MGMT_GPIO_BLINK_EN
  logic [NGPIO-1:0] blink_mask, out_wr;
  logic [23:0] blink_period, blink_cnt;
  logic tick;
  assign tick = blink_period != 24'd0 && blink_cnt == blink_period;
  // bits touched by a bus write this cycle win over the blink toggle
  assign out_wr = !wr ? '0 : a == 4'd0 ? bm : (a == 4'd6 || a == 4'd7) ? wd : '0;
  assign out_nxt = out_bus ^ (tick ? blink_mask & ~out_wr : '0);
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      blink_mask <= '0;
      blink_period <= '0;
      blink_cnt <= '0;
    end else begin
      if (wr && a == 4'd8) blink_mask <= (blink_mask & ~bm) | wd;
      if (wr && a == 4'd9) blink_period <= (blink_period & ~lanes[23:0]) | (wb_dat_i[23:0] & lanes[23:0]);
      blink_cnt <= ((wr && a == 4'd9) || tick || blink_period == 24'd0) ? '0 : blink_cnt + 24'd1;
    end
  end
`else
  assign out_nxt = out_bus;
`endif
  always_comb begin
    rd = '0;
    case (a)
      4'd0: rd = 32'(out_r);
      4'd1: rd = 32'(oeb_r);
      4'd2: rd = 32'(in_s);
      4'd3: rd = 32'(mask_r);
      4'd4: rd = 32'(edge_r);
      4'd5: rd = 32'(pend_r);
`ifdef MGMT_GPIO_BLINK_EN
      4'd8: rd = 32'(blink_mask);
      4'd9: rd = 32'(blink_period);
`endif
      default: rd = '0;
    endcase
  end
  always_ff @(posedge core_clk) begin
    if (core_rst) begin
      out_r <= '0;
      oeb_r <= OEB_RESET;
      mask_r <= '0;
      edge_r <= '0;
      pend_r <= '0;
      sync_q <= '0;
      prev <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      irq <= 1'b0;
    end else begin
      wb_ack_o <= acc;
      wb_dat_o <= acc ? rd : '0;
      out_r <= out_nxt;
      if (wr && a == 4'd1) oeb_r <= (oeb_r & ~bm) | wd;
      if (wr && a == 4'd3) mask_r <= (mask_r & ~bm) | wd;
      if (wr && a == 4'd4) edge_r <= (edge_r & ~bm) | wd;
      pend_r <= (pend_r & ~w1c) | ev;
      irq <= |(pend_r & mask_r);
      sync_q <= {sync_q[SYNC_STAGES-2:0], gpio_in};
      prev <= in_s;
    end
  end
endmodule

// File: tb/tb_mgmt_gpio_bank.sv
// tb_mgmt_gpio_bank: directed and randomized checks of mgmt_gpio_bank against a behavioural model.
module tb_mgmt_gpio_bank;
  logic core_clk = 0, core_rst = 1;
  logic cyc = 0, stb = 0, we = 0;
  logic [3:0] sel = 0;
  logic [5:0] adr = 0;
  logic [31:0] dat_i = 0, dat_o;
  logic ack, irq;
  logic [7:0] gpio_in = 0, gpio_out, gpio_oeb;
  int n_chk = 0, n_fail = 0;
  always #5 core_clk = ~core_clk;
  mgmt_gpio_bank dut (
    .core_clk(core_clk), .core_rst(core_rst),
    .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_sel_i(sel), .wb_adr_i(adr),
    .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_ack_o(ack),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oeb(gpio_oeb), .irq(irq)
  );
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // Reference model: registers as plain variables, pad seen through a two-cycle delay
  logic [7:0] m_out, m_oeb, m_mask, m_edge, m_pend;
  logic [7:0] dly [0:2];
  logic m_irq;
  logic [31:0] m_rd;
  bit acc_now = 0, wr_now = 0, chk_out = 1;
  logic [3:0] op_a = 0, op_sel = 0;
  logic [7:0] op_d = 0;
  function automatic logic [31:0] reg_val(logic [3:0] r);
    case (r)
      4'd0: return {24'b0, m_out};
      4'd1: return {24'b0, m_oeb};
      4'd2: return {24'b0, dly[1]};
      4'd3: return {24'b0, m_mask};
      4'd4: return {24'b0, m_edge};
      4'd5: return {24'b0, m_pend};
      default: return 32'b0;
    endcase
  endfunction
  always @(posedge core_clk) begin : model
    logic [7:0] d;
    logic irq_n;
    if (core_rst) begin
      m_out = 0; m_oeb = 8'hFF; m_mask = 0; m_edge = 0; m_pend = 0; m_irq = 0; m_rd = 0;
      dly[0] = 0; dly[1] = 0; dly[2] = 0;
    end else begin
      irq_n = |(m_pend & m_mask);
      if (acc_now) m_rd = reg_val(op_a);
      d = op_sel[0] ? op_d : 8'h00;
      if (wr_now)
        case (op_a)
          4'd0: m_out = op_sel[0] ? op_d : m_out;
          4'd1: m_oeb = op_sel[0] ? op_d : m_oeb;
          4'd3: m_mask = op_sel[0] ? op_d : m_mask;
          4'd4: m_edge = op_sel[0] ? op_d : m_edge;
          4'd6: m_out = m_out | d;
          4'd7: m_out = m_out & ~d;
          default: ;
        endcase
      for (int b = 0; b < 8; b++) begin
        if (wr_now && op_a == 4'd5 && d[b]) m_pend[b] = 1'b0;
        if (m_edge[b] ? (dly[1][b] && !dly[2][b]) : (!dly[1][b] && dly[2][b])) m_pend[b] = 1'b1;
      end
      m_irq = irq_n;
      dly[2] = dly[1]; dly[1] = dly[0]; dly[0] = gpio_in;
    end
  end
  always @(negedge core_clk)
    if (!core_rst) begin
      if (chk_out) check("gpio_out", {24'b0, gpio_out}, {24'b0, m_out});
      check("gpio_oeb", {24'b0, gpio_oeb}, {24'b0, m_oeb});
      check("irq", irq, m_irq);
    end
  task automatic idle(int n);
    repeat (n) begin @(posedge core_clk); #1; end
  endtask
  task automatic bus(input bit w, input logic [3:0] r, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] q, output logic [31:0] e);
    cyc = 1; stb = 1; we = w; adr = {r, 2'b00}; dat_i = d; sel = s;
    op_a = r; op_d = d[7:0]; op_sel = s; acc_now = 1; wr_now = w;
    @(posedge core_clk); #1;
    check("ack", ack, 1);
    q = dat_o; e = m_rd;
    cyc = 0; stb = 0; we = 0; acc_now = 0; wr_now = 0;
    @(posedge core_clk); #1;
    check("ack_idle", ack, 0);
  endtask
  task automatic wr(logic [3:0] r, logic [31:0] d, logic [3:0] s = 4'hF);
    logic [31:0] q, e;
    bus(1, r, d, s, q, e);
  endtask
  task automatic rd_exp(string tag, logic [3:0] r, logic [31:0] exp);
    logic [31:0] q, e;
    bus(0, r, 0, 4'hF, q, e);
    check(tag, q, exp);
  endtask
  task automatic rd_mdl(logic [3:0] r);
    logic [31:0] q, e;
    bus(0, r, 0, 4'hF, q, e);
    check($sformatf("rd_reg%0d", r), q, e);
  endtask
  initial begin
    int last_t, toggles;
    logic last_v;
    idle(3);
    core_rst = 0;
    check("rst_irq", irq, 0);
    check("rst_ack", ack, 0);
    rd_exp("rst_out", 0, 32'h0);
    rd_exp("rst_oeb", 1, 32'hFF);
    rd_exp("rst_mask", 3, 32'h0);
    rd_exp("rst_edge", 4, 32'h0);
    rd_exp("rst_pend", 5, 32'h0);
    rd_exp("rst_r8", 8, 32'h0);
    rd_exp("rst_r9", 9, 32'h0);
    wr(0, 32'hA5);
    check("out_a5", gpio_out, 8'hA5);
    rd_exp("rb_a5", 0, 32'hA5);
    wr(6, 32'h0A);
    check("out_set", gpio_out, 8'hAF);
    rd_exp("rb_af", 0, 32'hAF);
    wr(7, 32'h81);
    check("out_clr", gpio_out, 8'h2E);
    rd_exp("rb_2e", 0, 32'h2E);
    wr(0, 32'hFF, 4'h2);
    check("out_lane_gated", gpio_out, 8'h2E);
    wr(4, 32'h01);
    wr(3, 32'h01);
    gpio_in[0] = 1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge core_clk); #1;
      check($sformatf("irq_lat%0d", i), irq, i == 4);
    end
    rd_exp("in_pin0", 2, 32'h01);
    rd_exp("pend_pin0", 5, 32'h01);
    wr(5, 32'h01);
    check("irq_w1c", irq, 0);
    rd_exp("pend_w1c", 5, 32'h0);
    gpio_in[2] = 1;
    idle(1);
    rd_exp("in_1cyc", 2, 32'h01);
    gpio_in[3] = 1;
    idle(2);
    rd_exp("in_2cyc", 2, 32'h0D);
    gpio_in[1] = 1;
    idle(5);
    gpio_in[1] = 0;
    idle(5);
    rd_exp("pend_fall", 5, 32'h02);
    check("irq_masked", irq, 0);
    wr(3, 32'h03);
    check("irq_unmask", irq, 1);
    wr(5, 32'hFF);
    gpio_in[0] = 0;
    idle(4);
    gpio_in[0] = 1;
    idle(2);
    wr(5, 32'h01);
    rd_exp("pend_race", 5, 32'h01);
    cyc = 0; stb = 1; we = 1; adr = 6'h0; dat_i = 32'hFF; sel = 4'hF;
    idle(1);
    check("abort_ack", ack, 0);
    stb = 0; we = 0;
    rd_exp("abort_out", 0, 32'h2E);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
`ifdef MGMT_GPIO_BLINK_EN
        0: wr(4'($urandom_range(0, 7)), $urandom, 4'($urandom_range(0, 15)));
        1: rd_mdl(4'($urandom_range(0, 7)));
`else
        0: wr(4'($urandom_range(0, 9)), $urandom, 4'($urandom_range(0, 15)));
        1: rd_mdl(4'($urandom_range(0, 9)));
`endif
        2: begin gpio_in = 8'($urandom); idle(1); end
        default: begin gpio_in[$urandom_range(0, 7)] ^= 1'b1; idle($urandom_range(1, 4)); end
      endcase
    end
`ifdef MGMT_GPIO_BLINK_EN
    chk_out = 0;
    wr(8, 32'h01);
    wr(9, 32'd9);
    last_v = gpio_out[0]; last_t = -1; toggles = 0;
    for (int t = 0; t < 120; t++) begin
      idle(1);
      if (gpio_out[0] !== last_v) begin
        if (last_t >= 0) check("blink_interval", t - last_t, 10);
        last_t = t; last_v = gpio_out[0]; toggles++;
      end
    end
    check("blink_toggles", toggles >= 10, 1);
    wr(9, 32'd0);
    last_v = gpio_out[0]; toggles = 0;
    for (int t = 0; t < 40; t++) begin
      idle(1);
      if (gpio_out[0] !== last_v) begin toggles++; last_v = gpio_out[0]; end
    end
    check("blink_stopped", toggles, 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mgmt_gpio_bank.md
Name: mgmt_gpio_bank

Overview:
- Parametrised successor to the single-pin management GPIO.
- Provides NGPIO management-owned pins on the mgmt core Wishbone bus, with per-pin output, output-enable, synchronised input and edge-detect interrupts.
- Atomic set/clear registers allow firmware to toggle pins without read-modify-write.
- Sits beside the mgmt core; pins feed the pad ring, `irq` feeds the core interrupt controller.

Parameters:
- NGPIO, 8, number of pins (1..32).
- SYNC_STAGES, 2, input synchroniser depth (>=2).
- OEB_RESET, {NGPIO{1'b1}}, reset value of the output-enable-bar register (all pins input).

Ports:
- core_clk  in  1  sole clock.
- core_rst  in  1  synchronous reset, active-high.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_we_i  in  1  write enable.
- wb_sel_i  in  4  byte lanes.
- wb_adr_i  in  6  byte address; [5:2] selects the register.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_ack_o  out  1  acknowledge.
- gpio_in  in  NGPIO  asynchronous pad input.
- gpio_out  out  NGPIO  pad output value.
- gpio_oeb  out  NGPIO  pad output-enable, active-low.
- irq  out  1  level interrupt.

Behaviour:
- Reset (synchronous, core_rst=1 at posedge core_clk):
  - OUT=0, OEB=OEB_RESET, MASK=0, EDGE=0, PEND=0.
  - Synchroniser flops and previous-input flop = 0.
  - wb_ack_o=0, wb_dat_o=0, irq=0.
- Bus timing:
  - wb_ack_o is registered: ack <= cyc & stb & ~ack. Exactly one ack per access, 1 cycle after strobe, then idle at least 1 cycle.
  - Writes take effect on the ack edge.
  - Read data is valid with ack. Bits above NGPIO read 0.
  - wb_sel_i gates byte lanes on writes.
  - Unmapped addresses: ack normally, read 0, writes ignored.
  - Deasserting cyc before ack aborts cleanly; no register change.
- Register map (wb_adr_i[5:2]):
  - 0 OUT, rw.
  - 1 OEB, rw (1=input).
  - 2 IN, ro; synchronised input value.
  - 3 MASK, rw; interrupt enable.
  - 4 EDGE, rw; 1=rising, 0=falling.
  - 5 PEND, rw1c.
  - 6 SET, wo; 1 sets OUT bit.
  - 7 CLR, wo; 1 clears OUT bit.
  - 8-9 reserved for the optional feature.
- Pin outputs: gpio_out=OUT, gpio_oeb=OEB, both directly from flops.
- Input path: SYNC_STAGES flop chain produces in_s; prev <= in_s.
  - rise = in_s & ~prev; fall = ~in_s & prev.
  - Latency: pad change to IN readable = SYNC_STAGES cycles.
  - PEND bit sets SYNC_STAGES+1 cycles after the pad change.
- Edge detect / pending:
  - ev = EDGE ? rise : fall, per bit.
  - PEND <= (PEND & ~w1c) | ev. A new event and a W1C in the same cycle leave the bit set.
  - Edges are detected regardless of MASK; MASK gates only irq.
- irq: registered |(PEND & MASK); 1 cycle after the PEND update.
- OEB=1 does not block input sampling; an output pin reads back its own level.

Optional Feature:
- Macro: MGMT_GPIO_BLINK_EN.
- When defined:
  - Register 8 BLINK_MASK, rw, reset 0.
  - Register 9 BLINK_PERIOD, rw, 24 bits, reset 0.
  - A 24-bit prescaler counts core_clk. When count==BLINK_PERIOD and BLINK_PERIOD!=0, the counter wraps to 0 and OUT ^= BLINK_MASK.
  - A bus write to OUT/SET/CLR in the toggle cycle has priority for the bits it writes; the toggle applies to the remaining bits.
  - Writing BLINK_PERIOD clears the prescaler.
  - BLINK_PERIOD=0 stops blinking.
- When undefined: registers 8-9 read 0, writes ignored, no prescaler logic.

Test Plan:
- Reset held 3 cycles, then read all regs -> OUT=0, OEB=0xFF, MASK=0, PEND=0, irq=0. Each access acks exactly once, 1 cycle after stb.
- Write OUT=0xA5, SET=0x0A, CLR=0x81 -> gpio_out 0xA5 -> 0xAF -> 0x2E. Readback of OUT matches after each write.
- EDGE=0x01, MASK=0x01; drive gpio_in[0] 0->1 -> IN[0]=1 after 2 cycles, PEND=0x01 at 3, irq=1 at 4. W1C 0x01 -> irq=0.
- gpio_in[1] falling edge with EDGE[1]=0, MASK=0 -> PEND[1]=1 and irq stays 0. Set MASK[1] -> irq=1.
- Fire a rising edge on pin 0 in the same cycle as a W1C of PEND=0x01 -> PEND[0] remains 1.
- Blink (MGMT_GPIO_BLINK_EN): BLINK_MASK=0x01, BLINK_PERIOD=9 -> gpio_out[0] toggles every 10 cycles; 10 toggles observed. Period=0 -> toggling stops. Without the macro, regs 8-9 read 0.
